// File: rtl/mem_pkg.sv
// Shared definitions for the 4-write/1-read register-file memory and its
// write/read-side neighbours.
package mem_pkg;

   localparam int unsigned NUM_WPORTS = 4;

   typedef logic [1:0] wport_idx_t;

   // LSB of port slice 'port' in a packed per-port vector of 'width'-bit fields.
   function automatic int unsigned slice_lsb(int unsigned port, int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/mem_wr_conflict_arb.sv
// Combinational same-address collision resolver for the four write channels.
// Rotating priority starting at rp; reports grants, the next pointer and loser count.
module mem_wr_conflict_arb
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic [NUM_WPORTS-1:0]            req_valid,
   input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] req_addr,
   input  wport_idx_t                       rp,
   output logic [NUM_WPORTS-1:0]            grant,
   output wport_idx_t                       next_rp,
   output logic [1:0]                       lose_cnt
);

   logic [ADDR_WIDTH-1:0] addr_s [NUM_WPORTS];
   wport_idx_t            pos    [NUM_WPORTS];
   logic [NUM_WPORTS-1:0] blocked;
   logic [NUM_WPORTS-1:0] loser;
   logic [NUM_WPORTS-1:0] beat;
   wport_idx_t            ch;

   always_comb begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
         addr_s[i] = req_addr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
         // Position in this cycle's priority order; 0 is highest.
         pos[i]    = wport_idx_t'(i) - rp;
      end

      blocked = '0;
      for (int i = 0; i < NUM_WPORTS; i++) begin
         for (int j = 0; j < NUM_WPORTS; j++) begin
            if (j != i && req_valid[j] && addr_s[j] == addr_s[i] && pos[j] < pos[i]) begin
               blocked[i] = 1'b1;
            end
         end
      end
      grant = req_valid & ~blocked;
      loser = req_valid & ~grant;

      beat     = '0;
      lose_cnt = '0;
      for (int i = 0; i < NUM_WPORTS; i++) begin
         lose_cnt = lose_cnt + {1'b0, loser[i]};
         for (int j = 0; j < NUM_WPORTS; j++) begin
            if (loser[j] && grant[i] && addr_s[j] == addr_s[i]) begin
               beat[i] = 1'b1;
            end
         end
      end

      // Walk lowest priority first so the highest-priority winner is applied last.
      next_rp = rp;
      ch      = rp;
      for (int k = NUM_WPORTS - 1; k >= 0; k--) begin
         ch = rp + wport_idx_t'(k);
         if (beat[ch]) begin
            next_rp = ch + 2'd1;
         end
      end
   end

endmodule

// File: rtl/mem_wr_sched.sv
// Write scheduler: arbitrates four valid/ready write channels so at most one write
// per address reaches the memory each cycle; registered write ports plus stall counter.
module mem_wr_sched
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_WPORTS-1:0]            req_valid,
   output logic [NUM_WPORTS-1:0]            req_ready,
   input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_WPORTS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_WPORTS-1:0]            we,
   output logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr,
   output logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata,
   input  logic                            cnt_clr,
   output logic [CNT_WIDTH-1:0]             stall_cnt
);

   localparam int unsigned SUM_W = CNT_WIDTH + 1;

   logic [NUM_WPORTS-1:0]            grant;
   wport_idx_t                       next_rp;
   logic [1:0]                       lose_cnt;

   logic [NUM_WPORTS-1:0]            we_d, we_q;
   logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_d, waddr_q;
   logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_d, wdata_q;
   wport_idx_t                       rp_d, rp_q;
   logic [CNT_WIDTH-1:0]             stall_d, stall_q;
   logic [SUM_W-1:0]                 cnt_sum;

   mem_wr_conflict_arb #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_arb (
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .rp        (rp_q),
      .grant     (grant),
      .next_rp   (next_rp),
      .lose_cnt  (lose_cnt)
   );

   always_comb begin
      req_ready = rst_n ? grant : '0;
      we_d      = grant;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      rp_d      = next_rp;

      for (int i = 0; i < NUM_WPORTS; i++) begin
         if (grant[i]) begin
            waddr_d[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] =
               req_addr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
            wdata_d[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
               req_data[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
         end
      end

      cnt_sum = {1'b0, stall_q} + SUM_W'(lose_cnt);
      if (cnt_clr) begin
         stall_d = '0;
      end else if (cnt_sum[CNT_WIDTH]) begin
         stall_d = '1;
      end else begin
         stall_d = cnt_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         rp_q    <= '0;
         stall_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         rp_q    <= rp_d;
         stall_q <= stall_d;
      end
   end

   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign stall_cnt = stall_q;

endmodule
